// File: rtl/imem_arbiter.sv
// Arbiter giving the IFU and the debug/loader port shared access to a single-port instruction memory.
// Optional macro IMEM_ARB_RR_EN selects round-robin arbitration; otherwise DBG has fixed priority.
module imem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              ifu_req_vld,
    output logic              ifu_req_rdy,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_rsp_vld,
    output logic [DATA_W-1:0] ifu_rsp_data,
    output logic              ifu_rsp_err,
    input  logic              dbg_req_vld,
    output logic              dbg_req_rdy,
    input  logic              dbg_req_we,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    output logic              dbg_rsp_vld,
    output logic [DATA_W-1:0] dbg_rsp_data,
    output logic              dbg_rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, MEM, RSP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                owner_q, owner_d;   // 1 = DBG owns the access
    logic                err_q, err_d;
    logic                gnt_ifu, gnt_dbg;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   rsp_data;

`ifdef IMEM_ARB_RR_EN
    logic                last_dbg_q, last_dbg_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_dbg_q <= 1'b1;
        end else begin
            last_dbg_q <= last_dbg_d;
        end
    end
`endif

    // Grants are gated with reset so every output reads 0 while reset is held.
    always_comb begin
        gnt_ifu = 1'b0;
        gnt_dbg = 1'b0;
        if (state_q == IDLE && sys_rst_n) begin
`ifdef IMEM_ARB_RR_EN
            if (ifu_req_vld && dbg_req_vld) begin
                gnt_ifu = last_dbg_q;
                gnt_dbg = !last_dbg_q;
            end else begin
                gnt_ifu = ifu_req_vld;
                gnt_dbg = dbg_req_vld;
            end
`else
            gnt_dbg = dbg_req_vld;
            gnt_ifu = ifu_req_vld && !dbg_req_vld;
`endif
        end
    end

    assign ifu_req_rdy = gnt_ifu;
    assign dbg_req_rdy = gnt_dbg;
    assign gnt_addr    = gnt_dbg ? dbg_req_addr : ifu_req_addr;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        owner_d = owner_q;
        err_d   = err_q;
`ifdef IMEM_ARB_RR_EN
        last_dbg_d = last_dbg_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_ifu || gnt_dbg) begin
                    addr_d  = gnt_addr;
                    we_d    = gnt_dbg && dbg_req_we;
                    wdata_d = gnt_dbg ? dbg_req_wdata : '0;
                    owner_d = gnt_dbg;
                    err_d   = (gnt_addr[1:0] != 2'b00);
                    state_d = (gnt_addr[1:0] != 2'b00) ? RSP : MEM;
`ifdef IMEM_ARB_RR_EN
                    last_dbg_d = gnt_dbg;
`endif
                end
            end
            MEM:     state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign mem_en    = (state_q == MEM);
    assign mem_we    = (state_q == MEM) && we_q;
    assign mem_addr  = (state_q == MEM) ? addr_q : '0;
    assign mem_wdata = (state_q == MEM) ? wdata_q : '0;

    // Read data arrives in RSP, one cycle after the MEM strobe.
    assign rsp_data     = (!we_q && !err_q) ? mem_rdata : '0;
    assign ifu_rsp_vld  = (state_q == RSP) && !owner_q;
    assign dbg_rsp_vld  = (state_q == RSP) && owner_q;
    assign ifu_rsp_data = ifu_rsp_vld ? rsp_data : '0;
    assign dbg_rsp_data = dbg_rsp_vld ? rsp_data : '0;
    assign ifu_rsp_err  = ifu_rsp_vld && err_q;
    assign dbg_rsp_err  = dbg_rsp_vld && err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic against a cycle-level model.
module tb_imem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_vld, ifu_req_rdy;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_vld, ifu_rsp_err;
    logic [31:0] ifu_rsp_data;
    logic        dbg_req_vld, dbg_req_rdy, dbg_req_we;
    logic [31:0] dbg_req_addr, dbg_req_wdata;
    logic        dbg_rsp_vld, dbg_rsp_err;
    logic [31:0] dbg_rsp_data;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] tb_mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_val;
    logic [135:0] all_out;

    assign all_out = {ifu_req_rdy, dbg_req_rdy, ifu_rsp_vld, ifu_rsp_data, ifu_rsp_err,
                      dbg_rsp_vld, dbg_rsp_data, dbg_rsp_err, mem_en, mem_we, mem_addr[1:0],
                      mem_wdata[31:2] | mem_addr[31:2]};

    imem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .ifu_req_vld(ifu_req_vld), .ifu_req_rdy(ifu_req_rdy), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_vld(ifu_rsp_vld), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .dbg_req_vld(dbg_req_vld), .dbg_req_rdy(dbg_req_rdy), .dbg_req_we(dbg_req_we),
        .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_vld(dbg_rsp_vld), .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_err(dbg_rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port memory with one-cycle read latency, plus a backdoor load port.
    always @(posedge clk) begin
        if (bd_we) tb_mem[bd_idx] <= bd_val;
        else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr[7:2]];
        end
    end

    task automatic load_word(input int idx, input logic [31:0] val);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = 6'(idx); bd_val = val;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ifu_req_vld = 1'b1; dbg_req_vld = 1'b1; ifu_req_addr = 32'h10; dbg_req_addr = 32'h20;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
        ifu_req_vld = 1'b0; dbg_req_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL idle_outputs got=%h exp=0", all_out); end
        $display("test_reset done");
    endtask

    task automatic test_ifu_read;
        load_word(4, 32'h0000_0093);
        @(negedge clk);
        ifu_req_vld = 1'b1; ifu_req_addr = 32'h0000_0010; #1;
        checks++;
        if ({ifu_req_rdy, dbg_req_rdy} !== 2'b10) begin errors++; $display("FAIL rd_rdy got=%b exp=10", {ifu_req_rdy, dbg_req_rdy}); end
        @(negedge clk);
        ifu_req_vld = 1'b0; #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, ifu_rsp_vld} !== {2'b10, 32'h10, 1'b0}) begin
            errors++; $display("FAIL rd_mem got en=%b we=%b addr=%h rsp=%b exp en=1 we=0 addr=10 rsp=0", mem_en, mem_we, mem_addr, ifu_rsp_vld);
        end
        @(negedge clk); #1;
        checks++;
        if ({ifu_rsp_vld, ifu_rsp_data, ifu_rsp_err, dbg_rsp_vld, mem_en} !== {1'b1, 32'h93, 3'b000}) begin
            errors++; $display("FAIL rd_rsp got vld=%b data=%h err=%b dvld=%b en=%b exp 1 93 0 0 0", ifu_rsp_vld, ifu_rsp_data, ifu_rsp_err, dbg_rsp_vld, mem_en);
        end
        @(negedge clk); #1;
        checks++;
        if (ifu_rsp_vld !== 1'b0) begin errors++; $display("FAIL rd_rsp_once got=%b exp=0", ifu_rsp_vld); end
        $display("test_ifu_read done");
    endtask

    task automatic test_write_then_read;
        @(negedge clk);
        dbg_req_vld = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 32'h20; dbg_req_wdata = 32'hDEAD_BEEF; #1;
        checks++;
        if ({ifu_req_rdy, dbg_req_rdy} !== 2'b01) begin errors++; $display("FAIL wr_rdy got=%b exp=01", {ifu_req_rdy, dbg_req_rdy}); end
        @(negedge clk);
        dbg_req_vld = 1'b0; dbg_req_we = 1'b0; #1;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h20, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL wr_mem got en=%b we=%b addr=%h wd=%h exp 1 1 20 deadbeef", mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk); #1;
        checks++;
        if ({dbg_rsp_vld, dbg_rsp_data, dbg_rsp_err, ifu_rsp_vld} !== {1'b1, 32'h0, 2'b00}) begin
            errors++; $display("FAIL wr_rsp got vld=%b data=%h err=%b ivld=%b exp 1 0 0 0", dbg_rsp_vld, dbg_rsp_data, dbg_rsp_err, ifu_rsp_vld);
        end
        @(negedge clk);
        ifu_req_vld = 1'b1; ifu_req_addr = 32'h20; #1;
        checks++;
        if (ifu_req_rdy !== 1'b1) begin errors++; $display("FAIL wr_next_grant got=%b exp=1", ifu_req_rdy); end
        @(negedge clk);
        ifu_req_vld = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({ifu_rsp_vld, ifu_rsp_data} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL wr_readback got vld=%b data=%h exp 1 deadbeef", ifu_rsp_vld, ifu_rsp_data);
        end
        $display("test_write_then_read done");
    endtask

    task automatic test_misaligned;
        @(negedge clk);
        ifu_req_vld = 1'b1; ifu_req_addr = 32'h0000_0006; #1;
        checks++;
        if (ifu_req_rdy !== 1'b1) begin errors++; $display("FAIL mis_rdy got=%b exp=1", ifu_req_rdy); end
        @(negedge clk);
        ifu_req_vld = 1'b0; #1;
        checks++;
        if ({mem_en, ifu_rsp_vld, ifu_rsp_err, ifu_rsp_data} !== {3'b011, 32'h0}) begin
            errors++; $display("FAIL mis_rsp got en=%b vld=%b err=%b data=%h exp 0 1 1 0", mem_en, ifu_rsp_vld, ifu_rsp_err, ifu_rsp_data);
        end
        @(negedge clk); #1;
        checks++;
        if ({ifu_rsp_vld, mem_en} !== 2'b00) begin errors++; $display("FAIL mis_after got=%b exp=00", {ifu_rsp_vld, mem_en}); end
        $display("test_misaligned done");
    endtask

    task automatic test_contention;
        int order [4];
        int n = 0;
        int exp_o;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ifu_req_vld = 1'b1; ifu_req_addr = 32'h10;
        dbg_req_vld = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 32'h20;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (ifu_req_rdy) begin order[n] = 1; n++; end
            else if (dbg_req_rdy) begin order[n] = 2; n++; end
        end
        ifu_req_vld = 1'b0; dbg_req_vld = 1'b0;
        checks++;
        if (n != 4) begin errors++; $display("FAIL arb_grant_count got=%0d exp=4", n); end
        for (int i = 0; i < n; i++) begin
`ifdef IMEM_ARB_RR_EN
            exp_o = (i % 2 == 0) ? 1 : 2;
`else
            exp_o = 2;
`endif
            checks++;
            if (order[i] != exp_o) begin errors++; $display("FAIL arb_order[%0d] got=%0d exp=%0d (1=IFU 2=DBG)", i, order[i], exp_o); end
        end
        repeat (3) @(negedge clk);
        $display("test_contention done grants=%0d", n);
    endtask

    task automatic test_reset_in_mem;
        @(negedge clk);
        ifu_req_vld = 1'b1; ifu_req_addr = 32'h10;
        @(negedge clk);
        ifu_req_vld = 1'b0; #1;
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL rim_mem got=%b exp=1", mem_en); end
        rst_n = 1'b0; ifu_req_vld = 1'b1; #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL rim_outputs got=%h exp=0", all_out); end
        @(negedge clk); #1;
        checks++;
        if ({ifu_rsp_vld, dbg_rsp_vld, ifu_req_rdy} !== 3'b000) begin errors++; $display("FAIL rim_norsp got=%b exp=000", {ifu_rsp_vld, dbg_rsp_vld, ifu_req_rdy}); end
        ifu_req_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({ifu_rsp_vld, dbg_rsp_vld, mem_en} !== 3'b000) begin errors++; $display("FAIL rim_release got=%b exp=000", {ifu_rsp_vld, dbg_rsp_vld, mem_en}); end
        ifu_req_vld = 1'b1; ifu_req_addr = 32'h10; #1;
        checks++;
        if (ifu_req_rdy !== 1'b1) begin errors++; $display("FAIL rim_regrant got=%b exp=1", ifu_req_rdy); end
        @(negedge clk);
        ifu_req_vld = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({ifu_rsp_vld, ifu_rsp_data} !== {1'b1, 32'h93}) begin errors++; $display("FAIL rim_serve got vld=%b data=%h exp 1 93", ifu_rsp_vld, ifu_rsp_data); end
        $display("test_reset_in_mem done");
    endtask

    // Reference: one access at a time; an accepted request owns the memory until its response cycle.
    task automatic test_random;
        int t, idle_at, mem_cyc, rsp_cyc, g, idx, mis, nreq;
        bit last_dbg, pend_v, pend_dbg, pend_we, pend_err, exp_iv, exp_dv;
        logic [31:0] pend_addr, pend_wdata, pend_data, v;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            load_word(i, v);
        end
        t = 0; idle_at = 0; last_dbg = 1'b1; pend_v = 1'b0; nreq = 0;
        mem_cyc = -1; rsp_cyc = -1;
        pend_dbg = 0; pend_we = 0; pend_err = 0; pend_addr = 0; pend_wdata = 0; pend_data = 0;
        repeat (400) begin
            @(negedge clk);
            ifu_req_vld = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 63); mis = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            ifu_req_addr = 32'(idx * 4 + mis);
            dbg_req_vld = 1'($urandom_range(0, 1));
            dbg_req_we = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 63); mis = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            dbg_req_addr = 32'(idx * 4 + mis);
            dbg_req_wdata = $urandom;
            #1;
            checks++;
            if (mem_en !== (pend_v && t == mem_cyc)) begin errors++; $display("FAIL rnd_mem_en t=%0d got=%b exp=%b", t, mem_en, pend_v && t == mem_cyc); end
            if (pend_v && t == mem_cyc) begin
                checks++;
                if (mem_we !== pend_we || mem_addr !== pend_addr || (pend_we && mem_wdata !== pend_wdata)) begin
                    errors++; $display("FAIL rnd_mem_bus t=%0d got we=%b a=%h wd=%h exp we=%b a=%h wd=%h", t, mem_we, mem_addr, mem_wdata, pend_we, pend_addr, pend_wdata);
                end
            end
            exp_iv = pend_v && t == rsp_cyc && !pend_dbg;
            exp_dv = pend_v && t == rsp_cyc && pend_dbg;
            checks++;
            if (ifu_rsp_vld !== exp_iv || dbg_rsp_vld !== exp_dv) begin errors++; $display("FAIL rnd_rsp_vld t=%0d got=%b%b exp=%b%b", t, ifu_rsp_vld, dbg_rsp_vld, exp_iv, exp_dv); end
            if (exp_iv || exp_dv) begin
                checks++;
                if ((exp_iv ? {ifu_rsp_data, ifu_rsp_err} : {dbg_rsp_data, dbg_rsp_err}) !== {pend_data, pend_err}) begin
                    errors++; $display("FAIL rnd_rsp_data t=%0d got=%h/%b exp=%h/%b", t, exp_iv ? ifu_rsp_data : dbg_rsp_data, exp_iv ? ifu_rsp_err : dbg_rsp_err, pend_data, pend_err);
                end
            end
            g = 0;
            if (t >= idle_at) begin
`ifdef IMEM_ARB_RR_EN
                if (ifu_req_vld && dbg_req_vld) g = last_dbg ? 1 : 2;
`else
                if (ifu_req_vld && dbg_req_vld) g = 2;
`endif
                else if (dbg_req_vld) g = 2;
                else if (ifu_req_vld) g = 1;
            end
            checks++;
            if (ifu_req_rdy !== (g == 1) || dbg_req_rdy !== (g == 2)) begin errors++; $display("FAIL rnd_grant t=%0d got=%b%b exp=%b%b", t, ifu_req_rdy, dbg_req_rdy, g == 1, g == 2); end
            if (g != 0) begin
                nreq++;
                pend_v = 1'b1; pend_dbg = (g == 2); last_dbg = pend_dbg;
                pend_addr = pend_dbg ? dbg_req_addr : ifu_req_addr;
                pend_we = pend_dbg && dbg_req_we;
                pend_wdata = dbg_req_wdata;
                pend_err = (pend_addr % 4) != 0;
                mem_cyc = pend_err ? -1 : t + 1;
                rsp_cyc = pend_err ? t + 1 : t + 2;
                idle_at = rsp_cyc + 1;
                pend_data = (pend_err || pend_we) ? 32'h0 : ref_mem[pend_addr[7:2]];
                if (pend_we && !pend_err) ref_mem[pend_addr[7:2]] = pend_wdata;
            end
            t++;
        end
        @(negedge clk);
        ifu_req_vld = 1'b0; dbg_req_vld = 1'b0;
        repeat (3) @(negedge clk);
        $display("test_random done requests=%0d", nreq);
    endtask

    initial begin
        rst_n = 1'b0; bd_we = 1'b0; bd_idx = '0; bd_val = '0;
        ifu_req_vld = 1'b0; ifu_req_addr = '0;
        dbg_req_vld = 1'b0; dbg_req_we = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
        test_reset;
        test_ifu_read;
        test_write_then_read;
        test_misaligned;
        test_contention;
        test_reset_in_mem;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
